// File: rtl/bnn_pkg.sv
// Shared types for the BNN layer sequencer: core opcodes, sequencer states,
// the core's fixed normalise-to-activation latency, and a saturating increment.
package bnn_pkg;

    typedef enum logic [2:0] {
        OP_INI   = 3'd0,
        OP_ACC   = 3'd1,
        OP_POOL  = 3'd2,
        OP_NORM  = 3'd3,
        OP_NOP   = 3'd5,
        OP_NORM8 = 3'd7
    } bnn_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INI,
        S_ACC,
        S_POOL,
        S_NORM,
        S_WAIT,
        S_OUT
    } bnn_state_e;

    localparam int unsigned WAIT_CYC = 3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/bnn_seq_cnt.sv
// Loadable down-counter with a zero flag; used for the acc, pool and output loops.
module bnn_seq_cnt
    import bnn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bnn_seq.sv
// BNN layer sequencer: drives INI/ACC/POOL/NORM commands into the core and
// captures one activation word per pooled output. Macro BNN_SEQ_PERF_EN adds perf counters.
module bnn_seq
    import bnn_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NACC_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NACC_W-1:0] cfg_nacc,
    input  logic [1:0]        cfg_npool,
    input  logic [7:0]        cfg_nout,
    input  logic [ADDR_W-1:0] cfg_pbase,
    input  logic [ADDR_W-1:0] cfg_naddr,
    input  logic              cfg_norm8,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [31:0]       cmd_data,
    input  logic [31:0]       activ,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              busy,
    output logic              done
`ifdef BNN_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cyc,
    output logic [31:0]       perf_stall_in,
    output logic [31:0]       perf_stall_cmd
`endif
);

    bnn_state_e        state_q, state_d;
    logic [NACC_W-1:0] nacc_m1_q, nacc_m1_d;
    logic [1:0]        npool_q, npool_d;
    logic [7:0]        nout_m1_q, nout_m1_d;
    logic [ADDR_W-1:0] pbase_q, pbase_d, naddr_q, naddr_d, addr_q, addr_d;
    logic              norm8_q, norm8_d;
    logic [1:0]        wait_q, wait_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              launch;
    logic              acc_load, acc_dec, acc_zero;
    logic              pool_load, pool_dec, pool_zero;
    logic              out_load, out_dec, out_zero;
    logic [1:0]        pool_load_val;
    bnn_op_e           op_c;

    assign launch        = (state_q == S_IDLE) && start;
    assign pool_load_val = launch ? cfg_npool : npool_q;

    bnn_seq_cnt #(.W(NACC_W)) u_acc_cnt (
        .clk(clk), .rst(rst), .load(acc_load), .load_val(nacc_m1_q), .dec(acc_dec), .zero(acc_zero)
    );
    bnn_seq_cnt #(.W(2)) u_pool_cnt (
        .clk(clk), .rst(rst), .load(pool_load), .load_val(pool_load_val), .dec(pool_dec), .zero(pool_zero)
    );
    bnn_seq_cnt #(.W(8)) u_out_cnt (
        .clk(clk), .rst(rst), .load(out_load), .load_val(nout_m1_d), .dec(out_dec), .zero(out_zero)
    );

    always_comb begin
        state_d    = state_q;
        nacc_m1_d  = nacc_m1_q;
        npool_d    = npool_q;
        nout_m1_d  = nout_m1_q;
        pbase_d    = pbase_q;
        naddr_d    = naddr_q;
        norm8_d    = norm8_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        acc_load   = 1'b0;
        acc_dec    = 1'b0;
        pool_load  = 1'b0;
        pool_dec   = 1'b0;
        out_load   = 1'b0;
        out_dec    = 1'b0;
        cmd_valid  = 1'b0;
        op_c       = OP_NOP;
        cmd_addr   = '0;
        cmd_data   = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nacc_m1_d = (cfg_nacc == '0) ? '0 : cfg_nacc - NACC_W'(1);
                    npool_d   = cfg_npool;
                    nout_m1_d = (cfg_nout == '0) ? '0 : cfg_nout - 8'd1;
                    pbase_d   = cfg_pbase;
                    naddr_d   = cfg_naddr;
                    norm8_d   = cfg_norm8;
                    pool_load = 1'b1;
                    out_load  = 1'b1;
                    state_d   = S_INI;
                end
            end
            S_INI: begin
                cmd_valid = 1'b1;
                op_c      = OP_INI;
                cmd_addr  = pbase_q;
                if (cmd_ready) begin
                    acc_load = 1'b1;
                    addr_d   = pbase_q;
                    state_d  = S_ACC;
                end
            end
            S_ACC: begin
                // Without input data the core still gets a NOP so the slot is not lost.
                cmd_valid = 1'b1;
                cmd_addr  = addr_q;
                cmd_data  = in_data;
                in_ready  = cmd_ready;
                op_c      = in_valid ? OP_ACC : OP_NOP;
                if (cmd_ready && in_valid) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    acc_dec = 1'b1;
                    if (acc_zero) state_d = S_POOL;
                end
            end
            S_POOL: begin
                cmd_valid = 1'b1;
                op_c      = OP_POOL;
                if (cmd_ready) begin
                    if (pool_zero) begin
                        state_d = S_NORM;
                    end else begin
                        pool_dec = 1'b1;
                        state_d  = S_INI;
                    end
                end
            end
            S_NORM: begin
                cmd_valid = 1'b1;
                op_c      = norm8_q ? OP_NORM8 : OP_NORM;
                cmd_addr  = naddr_q;
                if (cmd_ready) begin
                    pool_load = 1'b1;
                    wait_d    = 2'(WAIT_CYC - 1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cmd_valid = 1'b1;
                if (wait_q == '0) begin
                    out_data_d = activ;
                    state_d    = S_OUT;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_OUT: begin
                cmd_valid = 1'b1;
                out_valid = 1'b1;
                if (out_zero) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    out_dec = 1'b1;
                    state_d = S_INI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nacc_m1_q  <= '0;
            npool_q    <= '0;
            nout_m1_q  <= '0;
            pbase_q    <= '0;
            naddr_q    <= '0;
            norm8_q    <= 1'b0;
            addr_q     <= '0;
            wait_q     <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nacc_m1_q  <= nacc_m1_d;
            npool_q    <= npool_d;
            nout_m1_q  <= nout_m1_d;
            pbase_q    <= pbase_d;
            naddr_q    <= naddr_d;
            norm8_q    <= norm8_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    assign cmd_op   = op_c;
    assign out_data = out_data_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

`ifdef BNN_SEQ_PERF_EN
    logic [31:0] perf_cyc_q, perf_cyc_d, perf_sin_q, perf_sin_d, perf_scmd_q, perf_scmd_d;

    always_comb begin
        perf_cyc_d  = sat_inc(perf_cyc_q, busy);
        perf_sin_d  = sat_inc(perf_sin_q, (state_q == S_ACC) && !in_valid);
        perf_scmd_d = sat_inc(perf_scmd_q, cmd_valid && !cmd_ready);
        if (launch) begin
            perf_cyc_d  = '0;
            perf_sin_d  = '0;
            perf_scmd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cyc_q  <= '0;
            perf_sin_q  <= '0;
            perf_scmd_q <= '0;
        end else begin
            perf_cyc_q  <= perf_cyc_d;
            perf_sin_q  <= perf_sin_d;
            perf_scmd_q <= perf_scmd_d;
        end
    end

    assign perf_cyc       = perf_cyc_q;
    assign perf_stall_in  = perf_sin_q;
    assign perf_stall_cmd = perf_scmd_q;
`endif

endmodule
